pellet_score: RTL

Pellet bitmap and score keeper for the Pacman game. Sits directly downstream of the pacman movement control: it consumes Pacman's pixel position and the crash/over flag, clears eaten pellets from a 20×15 tile bitmap, and accumulates a 4-digit BCD score. Its outputs feed two blocks:
- the 7-segment data word consumed by `Seg7Device`;
- a registered pellet-query port used by `Display` to draw remaining pellets.

---
 rtl/pacman_pkg.sv | 22 ++
 rtl/pellet_score_bcd_add4.sv | 29 ++
 rtl/pellet_score.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pacman_pkg.sv
// Shared constants, FSM state type and tile-index helper for the Pacman
// pellet/score logic.
package pacman_pkg;

    localparam int          TILE_COLS     = 20;
    localparam int          TILE_ROWS     = 15;
    localparam int          N_TILES       = 300;
    localparam logic [15:0] SCORE_MAX_BCD = 16'h9990;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        WON    = 2'd2,
        FROZEN = 2'd3
    } state_e;

    // row*20 + col without a multiplier
    function automatic logic [8:0] tile_index(input logic [3:0] row, input logic [4:0] col);
        return ({5'd0, row} << 4) + ({5'd0, row} << 2) + {4'd0, col};
    endfunction

endpackage

// File: rtl/pellet_score_bcd_add4.sv
// Combinational 4-digit BCD adder; results above SCORE_MAX_BCD (or a carry
// out of the top digit) clamp to SCORE_MAX_BCD.
module bcd_add4 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    import pacman_pkg::*;

    logic [4:0]  digit;
    logic        carry;
    logic [15:0] raw;

    always_comb begin
        digit = '0;
        carry = 1'b0;
        raw   = '0;
        for (int d = 0; d < 4; d++) begin
            digit = {1'b0, a_i[d*4 +: 4]} + {1'b0, b_i[d*4 +: 4]} + {4'd0, carry};
            carry = (digit > 5'd9);
            if (carry) begin
                digit = digit + 5'd6;
            end
            raw[d*4 +: 4] = digit[3:0];
        end
        sum_o = (carry || (raw > SCORE_MAX_BCD)) ? SCORE_MAX_BCD : raw;
    end

endmodule

// File: rtl/pellet_score.sv
// Pellet bitmap and BCD score keeper: clears eaten pellets through a 3-stage
// pipeline and exposes a registered pellet query for the display.
module pellet_score #(
    parameter int TILE_COLS  = 20,
    parameter int TILE_ROWS  = 15,
    parameter int PELLET_PTS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [9:0]  PacY,
    input  logic        over,
    input  logic [4:0]  q_tile_x,
    input  logic [3:0]  q_tile_y,
    output logic        q_pellet,
    output logic [15:0] score,
    output logic [8:0]  remaining,
    output logic        won,
    output logic        ready,
    output logic [31:0] seg_data,
    output logic [1:0]  dbg_state
);
    import pacman_pkg::*;

    localparam logic [4:0]  COL_LIMIT = 5'(TILE_COLS);
    localparam logic [3:0]  ROW_LIMIT = 4'(TILE_ROWS);
    localparam logic [8:0]  TILE_CNT  = 9'(N_TILES);
    localparam logic [8:0]  LAST_IDX  = 9'(N_TILES - 1);
    localparam logic [15:0] PTS_BCD   = {8'h00, 4'(PELLET_PTS / 10), 4'h0};

    state_e              state_q, state_d;
    logic [8:0]          init_idx_q, init_idx_d;
    logic [N_TILES-1:0]  bitmap_q;

    logic                s0_valid_q, s0_valid_d;
    logic [8:0]          s0_idx_q, s0_idx_d;
    logic                s1_hit_q, s1_hit_d;
    logic [8:0]          s1_idx_q, s1_idx_d;
    logic [15:0]         score_q, score_d;
    logic [8:0]          remaining_q, remaining_d;
    logic                q_pellet_q, q_pellet_d;

    logic [4:0]          pac_col;
    logic [3:0]          pac_row;
    logic                pac_in_range;
    logic                q_in_range;
    logic [8:0]          q_idx;
    logic                eat_fire;
    logic [15:0]         score_sum;
    logic                unused_pacy;

    assign pac_col      = PacX[9:5];
    assign pac_row      = PacY[8:5];
    assign unused_pacy  = PacY[9];
    assign pac_in_range = (pac_col < COL_LIMIT) && (pac_row < ROW_LIMIT);
    assign q_in_range   = (q_tile_x < COL_LIMIT) && (q_tile_y < ROW_LIMIT);
    assign q_idx        = tile_index(q_tile_y, q_tile_x);

    // A clear in the cycle over is seen is dropped so the frozen score is final.
    assign eat_fire = (state_q == RUN) && s1_hit_q && !over && (remaining_q != 9'd0);

    bcd_add4 u_add (
        .a_i   (score_q),
        .b_i   (PTS_BCD),
        .sum_o (score_sum)
    );

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 9'd1;
                if (init_idx_q == LAST_IDX) begin
                    state_d    = RUN;
                    init_idx_d = '0;
                end
            end
            RUN: begin
                if (over) begin
                    state_d = FROZEN;
                end else if (eat_fire && (remaining_q == 9'd1)) begin
                    state_d = WON;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s0_valid_d  = (state_q == RUN) && pac_in_range;
        s0_idx_d    = tile_index(pac_row, pac_col);
        s1_idx_d    = s0_idx_q;
        // Forward the S2 clear so a same-tile sample right behind it reads empty.
        s1_hit_d    = (state_q == RUN) && s0_valid_q && bitmap_q[s0_idx_q]
                      && !(eat_fire && (s1_idx_q == s0_idx_q));
        score_d     = eat_fire ? score_sum : score_q;
        remaining_d = eat_fire ? (remaining_q - 9'd1) : remaining_q;
        q_pellet_d  = (state_q != INIT) && q_in_range && bitmap_q[q_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            s0_valid_q  <= 1'b0;
            s0_idx_q    <= '0;
            s1_hit_q    <= 1'b0;
            s1_idx_q    <= '0;
            score_q     <= '0;
            remaining_q <= TILE_CNT;
            q_pellet_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            s0_valid_q  <= s0_valid_d;
            s0_idx_q    <= s0_idx_d;
            s1_hit_q    <= s1_hit_d;
            s1_idx_q    <= s1_idx_d;
            score_q     <= score_d;
            remaining_q <= remaining_d;
            q_pellet_q  <= q_pellet_d;
        end
    end

    // Bitmap has no reset: INIT rewrites every entry before RUN can read it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            bitmap_q[init_idx_q] <= 1'b1;
        end else if (eat_fire) begin
            bitmap_q[s1_idx_q] <= 1'b0;
        end
    end

    assign q_pellet  = q_pellet_q;
    assign score     = score_q;
    assign remaining = remaining_q;
    assign won       = (state_q == WON);
    assign ready     = (state_q != INIT);
    assign seg_data  = {7'b0, remaining_q, score_q};
    assign dbg_state = state_q;

endmodule
